// File: rtl/bullet_engine.sv
// bullet_engine: bullet slot manager.
// Turns each level change of the bullet-rate toggle into one movement step,
// spawns bullets at the player's X on fire button rising edges (subject to a
// step-based cooldown and slot availability) and retires bullets that pass
// the top of the screen. All outputs come straight from registers.
module bullet_engine #(
    parameter int NUM_BULLETS    = 4,
    parameter int X_W            = 10,
    parameter int Y_W            = 10,
    parameter int SPAWN_Y        = 440,
    parameter int STEP           = 4,
    parameter int TOP_Y          = 0,
    parameter int COOLDOWN_STEPS = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               bullet_update_i,
    input  logic                               fire_i,
    input  logic [X_W-1:0]                     player_x_i,
    output logic [NUM_BULLETS-1:0]             bullet_valid_o,
    output logic [NUM_BULLETS*X_W-1:0]         bullet_x_o,
    output logic [NUM_BULLETS*Y_W-1:0]         bullet_y_o,
    output logic                               fire_ack_o,
    output logic                               fire_drop_o,
    output logic [$clog2(NUM_BULLETS+1)-1:0]   active_count_o
);

    localparam int CNT_W = $clog2(NUM_BULLETS + 1);
    // A zero cooldown still needs a one-bit counter that simply stays at 0.
    localparam int CD_W  = (COOLDOWN_STEPS > 0) ? $clog2(COOLDOWN_STEPS + 1) : 1;

    // Retire threshold is one bit wider than Y so TOP_Y + STEP never wraps.
    localparam logic [Y_W:0]      RETIRE_LIM = (Y_W + 1)'(TOP_Y + STEP);
    localparam logic [Y_W-1:0]    STEP_Y     = Y_W'(STEP);
    localparam logic [Y_W-1:0]    SPAWN_VAL  = Y_W'(SPAWN_Y);
    localparam logic [CD_W-1:0]   CD_LOAD    = CD_W'(COOLDOWN_STEPS);

    // Number of set bits in a slot vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_BULLETS-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < NUM_BULLETS; k++) begin
            cnt = cnt + CNT_W'(vec[k]);
        end
        return cnt;
    endfunction

    logic                         r_upd_q;
    logic                         r_fire_q;
    logic [NUM_BULLETS-1:0]       r_valid;
    logic [NUM_BULLETS*X_W-1:0]   r_x;
    logic [NUM_BULLETS*Y_W-1:0]   r_y;
    logic [CD_W-1:0]              r_cooldown;
    logic                         r_fire_ack;
    logic                         r_fire_drop;
    logic [CNT_W-1:0]             r_count;

    logic                         w_step;
    logic                         w_fire_rise;
    logic [NUM_BULLETS-1:0]       w_free;
    logic [NUM_BULLETS-1:0]       w_spawn_mask;
    logic                         w_accept;
    logic [NUM_BULLETS-1:0]       w_valid_nxt;
    logic [NUM_BULLETS*X_W-1:0]   w_x_nxt;
    logic [NUM_BULLETS*Y_W-1:0]   w_y_nxt;
    logic [CD_W-1:0]              w_cooldown_nxt;

    assign w_step      = bullet_update_i ^ r_upd_q;
    assign w_fire_rise = fire_i & ~r_fire_q;

    // Free slots are judged on the pre-step state, so a slot retiring this
    // cycle cannot be reused by a simultaneous fire.
    assign w_free       = ~r_valid;
    assign w_spawn_mask = w_free & (~w_free + NUM_BULLETS'(1));
    assign w_accept     = w_fire_rise & (r_cooldown == '0) & (|w_free);

    // Next slot state: move or retire live bullets on a step, then overlay the spawn.
    always_comb begin
        w_valid_nxt = r_valid;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        for (int k = 0; k < NUM_BULLETS; k++) begin
            if (w_step && r_valid[k]) begin
                if ({1'b0, r_y[k*Y_W +: Y_W]} < RETIRE_LIM) begin
                    w_valid_nxt[k] = 1'b0;
                end else begin
                    w_y_nxt[k*Y_W +: Y_W] = r_y[k*Y_W +: Y_W] - STEP_Y;
                end
            end else begin
                w_valid_nxt[k] = r_valid[k];
            end
            if (w_accept && w_spawn_mask[k]) begin
                w_valid_nxt[k]        = 1'b1;
                w_x_nxt[k*X_W +: X_W] = player_x_i;
                w_y_nxt[k*Y_W +: Y_W] = SPAWN_VAL;
            end else begin
                w_x_nxt[k*X_W +: X_W] = w_x_nxt[k*X_W +: X_W];
            end
        end
    end

    // Next cooldown: a spawn reloads it and overrides a same-cycle step decrement.
    always_comb begin
        w_cooldown_nxt = r_cooldown;
        if (w_accept) begin
            w_cooldown_nxt = CD_LOAD;
        end else if (w_step && (r_cooldown != '0)) begin
            w_cooldown_nxt = r_cooldown - CD_W'(1);
        end else begin
            w_cooldown_nxt = r_cooldown;
        end
    end

    // Toggle history follows the input even in reset, so release never fakes a step.
    always_ff @(posedge clk_i) begin
        r_upd_q <= bullet_update_i;
    end

    // Slot, cooldown and output pulse registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fire_q    <= 1'b0;
            r_valid     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_cooldown  <= '0;
            r_fire_ack  <= 1'b0;
            r_fire_drop <= 1'b0;
            r_count     <= '0;
        end else begin
            r_fire_q    <= fire_i;
            r_valid     <= w_valid_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_cooldown  <= w_cooldown_nxt;
            r_fire_ack  <= w_fire_rise & w_accept;
            r_fire_drop <= w_fire_rise & ~w_accept;
            r_count     <= popcount(w_valid_nxt);
        end
    end

    assign bullet_valid_o = r_valid;
    assign bullet_x_o     = r_x;
    assign bullet_y_o     = r_y;
    assign fire_ack_o     = r_fire_ack;
    assign fire_drop_o    = r_fire_drop;
    assign active_count_o = r_count;

endmodule
